// File: rtl/bird_pkg.sv
// bird_pkg: shared types and helpers for the bird vertical-physics slice.
//   state_t      : game state (IDLE / RUN / DEAD)
//   DEF_FRAC     : default number of fractional bits in position/velocity
//   ONE_PX       : one pixel expressed in the default Q format
//   floor_limit(): lowest legal sprite row for a given screen/sprite height
package bird_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam int unsigned DEF_FRAC = 32'd4;
  localparam int unsigned ONE_PX   = 32'd1 << DEF_FRAC;

  // Row at which the sprite bottom touches the screen bottom.
  function automatic int floor_limit(input int screen_h, input int bird_h);
    return screen_h - bird_h;
  endfunction

endpackage

// File: rtl/bird_flap_latch.sv
// bird_flap_latch: turns the debounced flap level into a one-per-press request.
//   clk, reset_n : clock, asynchronous active-low reset
//   flap_btn     : debounced flap level
//   tick         : physics update cycle; consumes the pending request
//   dead         : game over; requests are discarded and not stored
//   flap_now     : a flap applies to an update taken in this cycle
//                  (pending request or a rise in this very cycle)
module bird_flap_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic flap_btn,
  input  logic tick,
  input  logic dead,
  output logic flap_now
);

  logic flap_d_r;
  logic pend_r;
  logic rise_s;

  assign rise_s   = flap_btn & ~flap_d_r;
  assign flap_now = ~dead & (pend_r | rise_s);

  // Edge-detect history and the pending-flap flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flap_d_r <= 1'b0;
      pend_r   <= 1'b0;
    end else begin
      flap_d_r <= flap_btn;
      if (dead) begin
        pend_r <= 1'b0;
      end else if (tick) begin
        pend_r <= 1'b0;
      end else if (rise_s) begin
        pend_r <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

endmodule

// File: rtl/bird_kinematics.sv
// bird_kinematics: fixed-point vertical physics of the bird with IDLE/RUN/DEAD game FSM.
//   clk, reset_n : clock, asynchronous active-low reset
//   flap_btn     : debounced flap level
//   collide      : obstacle hit (level), latched while running
//   restart      : new-game request, only acted on in DEAD
//   bird_y       : integer part of the position, px (0 = top)
//   velocity     : signed velocity, Q.FRAC
//   alive        : high in RUN
//   game_over    : high in DEAD
//   tick_o       : high during each physics update cycle
// Build option BIRD_CEIL_CLAMP_EN: hitting the ceiling clamps the bird at row 0
// with zero velocity and keeps the game running instead of ending it.
module bird_kinematics
  import bird_pkg::*;
#(
  parameter int YW       = 10,
  parameter int FRAC     = 4,
  parameter int VW       = 12,
  parameter int SCREEN_H = 480,
  parameter int BIRD_H   = 24,
  parameter int START_Y  = 200,
  parameter int GRAVITY  = 32,
  parameter int FLAP_V   = -96,
  parameter int MAX_FALL = 80,
  parameter int TICK_W   = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flap_btn,
  input  logic                 collide,
  input  logic                 restart,
  output logic [YW-1:0]        bird_y,
  output logic signed [VW-1:0] velocity,
  output logic                 alive,
  output logic                 game_over,
  output logic                 tick_o
);

  localparam int QW       = YW + FRAC;
  // Two extra bits keep the trial position signed and free of wrap.
  localparam int PW       = QW + 2;
  localparam int FLOOR_PX = floor_limit(SCREEN_H, BIRD_H);

  localparam logic [QW-1:0]        START_P  = QW'(START_Y << FRAC);
  localparam logic [QW-1:0]        FLOOR_P  = QW'(FLOOR_PX << FRAC);
  localparam logic signed [PW-1:0] FLOOR_PQ = PW'(FLOOR_PX << FRAC);
  localparam logic signed [VW-1:0] FLAP_VQ  = VW'(FLAP_V);
  localparam logic signed [VW-1:0] MAXF_VQ  = VW'(MAX_FALL);
  localparam logic signed [VW:0]   GRAV_X   = (VW+1)'(GRAVITY);
  localparam logic signed [VW:0]   MAXF_X   = (VW+1)'(MAX_FALL);
  // Counter value one cycle before the update cycle (all-ones minus one).
  localparam logic [TICK_W-1:0]    TICK_PRE = ~TICK_W'(1);

  logic [TICK_W-1:0]    cnt_r;
  logic                 tick_r;
  state_t               state_r;
  logic [QW-1:0]        p_r;
  logic signed [VW-1:0] v_r;
  logic                 alive_r;
  logic                 over_r;
  logic                 coll_pend_r;

  logic                 update_s;
  logic                 in_run_s;
  logic                 dead_s;
  logic                 flap_now_s;
  logic                 coll_now_s;
  logic signed [VW:0]   v_sum_s;
  logic signed [VW-1:0] v_next_s;
  logic signed [PW-1:0] p_sum_s;
  logic                 ceil_s;
  logic                 floor_s;
  state_t               step_state_s;
  logic [QW-1:0]        step_p_s;
  logic signed [VW-1:0] step_v_s;

  assign update_s   = &cnt_r;
  assign in_run_s   = (state_r == ST_RUN);
  assign dead_s     = (state_r == ST_DEAD);
  // A collide level in the update cycle itself still counts for that update.
  assign coll_now_s = in_run_s & (coll_pend_r | collide);

  bird_flap_latch u_flap (
    .clk      (clk),
    .reset_n  (reset_n),
    .flap_btn (flap_btn),
    .tick     (update_s),
    .dead     (dead_s),
    .flap_now (flap_now_s)
  );

  // Candidate velocity and position for the next physics step.
  always_comb begin
    v_sum_s = {v_r[VW-1], v_r} + GRAV_X;
    if (flap_now_s) begin
      v_next_s = FLAP_VQ;
    end else if (v_sum_s > MAXF_X) begin
      v_next_s = MAXF_VQ;
    end else begin
      v_next_s = v_sum_s[VW-1:0];
    end
    p_sum_s = {{(PW-QW){1'b0}}, p_r} + {{(PW-VW){v_next_s[VW-1]}}, v_next_s};
    ceil_s  = p_sum_s[PW-1] | (p_sum_s == {PW{1'b0}});
    floor_s = ~ceil_s & (p_sum_s >= FLOOR_PQ);
  end

  // Outcome of a step: collision first, then ceiling, then floor.
  always_comb begin
    step_state_s = ST_RUN;
    step_p_s     = p_sum_s[QW-1:0];
    step_v_s     = v_next_s;
    if (coll_now_s) begin
      step_state_s = ST_DEAD;
      step_p_s     = p_r;
      step_v_s     = {VW{1'b0}};
    end else if (ceil_s) begin
`ifdef BIRD_CEIL_CLAMP_EN
      step_state_s = ST_RUN;
`else
      step_state_s = ST_DEAD;
`endif
      step_p_s     = {QW{1'b0}};
      step_v_s     = {VW{1'b0}};
    end else if (floor_s) begin
      step_state_s = ST_DEAD;
      step_p_s     = FLOOR_P;
      step_v_s     = {VW{1'b0}};
    end else begin
      step_state_s = ST_RUN;
    end
  end

  // Tick counter, collision latch and the game FSM with its registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r       <= {TICK_W{1'b0}};
      tick_r      <= 1'b0;
      state_r     <= ST_IDLE;
      p_r         <= START_P;
      v_r         <= {VW{1'b0}};
      alive_r     <= 1'b0;
      over_r      <= 1'b0;
      coll_pend_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_r + TICK_W'(1);
      tick_r      <= (cnt_r == TICK_PRE);
      coll_pend_r <= (in_run_s && !update_s) ? (coll_pend_r | collide) : 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (update_s && flap_now_s) begin
            state_r <= step_state_s;
            p_r     <= step_p_s;
            v_r     <= step_v_s;
            alive_r <= (step_state_s == ST_RUN);
            over_r  <= (step_state_s == ST_DEAD);
          end else begin
            p_r <= START_P;
            v_r <= {VW{1'b0}};
          end
        end
        ST_RUN: begin
          if (update_s) begin
            state_r <= step_state_s;
            p_r     <= step_p_s;
            v_r     <= step_v_s;
            alive_r <= (step_state_s == ST_RUN);
            over_r  <= (step_state_s == ST_DEAD);
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DEAD: begin
          if (restart) begin
            state_r <= ST_IDLE;
            p_r     <= START_P;
            v_r     <= {VW{1'b0}};
            alive_r <= 1'b0;
            over_r  <= 1'b0;
          end else begin
            state_r <= ST_DEAD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          p_r     <= START_P;
          v_r     <= {VW{1'b0}};
          alive_r <= 1'b0;
          over_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bird_y    = p_r[QW-1:FRAC];
  assign velocity  = v_r;
  assign alive     = alive_r;
  assign game_over = over_r;
  assign tick_o    = tick_r;

endmodule

// File: tb/tb_bird_kinematics.sv
// tb_bird_kinematics: directed self-checking bench for bird_kinematics with TICK_W=2
// (one physics update every 4 clocks). Expected values are hand-computed.
module tb_bird_kinematics;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               flap_btn;
  logic               collide;
  logic               restart;
  logic [9:0]         bird_y;
  logic signed [11:0] velocity;
  logic               alive;
  logic               game_over;
  logic               tick_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bird_kinematics #(.TICK_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flap_btn  (flap_btn),
    .collide   (collide),
    .restart   (restart),
    .bird_y    (bird_y),
    .velocity  (velocity),
    .alive     (alive),
    .game_over (game_over),
    .tick_o    (tick_o)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int y, input int v,
                           input logic a, input logic g);
    check({tag, "_y"}, bird_y, y);
    check({tag, "_v"}, velocity, v);
    check({tag, "_alive"}, alive, a);
    check({tag, "_over"}, game_over, g);
  endtask

  // Advance to the next negedge at which tick_o is high (the update cycle).
  task automatic wait_update(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tick_o !== 1'b1 && k < 8);
    check({tag, "_tick_wait"}, tick_o, 1);
  endtask

  initial begin
    int exp_v[7];
    int exp_y[7];
    int n;
    exp_v = '{-64, -32, 0, 32, 64, 80, 80};
    exp_y = '{190, 188, 188, 190, 194, 199, 204};

    reset_n  = 1'b0;
    flap_btn = 1'b0;
    collide  = 1'b0;
    restart  = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 200, 0, 1'b0, 1'b0);
    check("reset_tick", tick_o, 0);
    reset_n = 1'b1;

    // 1: idle without flap, tick every 4 cycles
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      check("idle_tick", tick_o, (i % 4 == 3) ? 1 : 0);
      check_all("idle", 200, 0, 1'b0, 1'b0);
    end

    // 2: one-cycle flap starts the game
    flap_btn = 1'b1;
    @(negedge clk);
    flap_btn = 1'b0;
    wait_update("start");
    @(negedge clk);
    check_all("start", 194, -96, 1'b1, 1'b0);

    // 3: free fall with velocity cap
    for (int i = 0; i < 7; i++) begin
      wait_update("fall");
      @(negedge clk);
      check_all("fall", exp_y[i], exp_v[i], 1'b1, 1'b0);
    end

    // 4: fall to the floor
    n = 0;
    while (game_over !== 1'b1 && n < 60) begin
      wait_update("floor");
      @(negedge clk);
      n++;
    end
    check("floor_ticks", n, 51);
    check_all("floor", 456, 0, 1'b0, 1'b1);
    flap_btn = 1'b1;
    @(negedge clk);
    flap_btn = 1'b0;
    wait_update("dead_flap");
    @(negedge clk);
    check_all("dead_flap", 456, 0, 1'b0, 1'b1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_all("restart1", 200, 0, 1'b0, 1'b0);

    // held flap level gives a single flap; restart ignored in RUN
    flap_btn = 1'b1;
    wait_update("held");
    @(negedge clk);
    check_all("held1", 194, -96, 1'b1, 1'b0);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_all("run_restart", 194, -96, 1'b1, 1'b0);
    wait_update("held2");
    @(negedge clk);
    check_all("held2", 190, -64, 1'b1, 1'b0);

    // 6: collide between ticks plus flap on the update cycle
    flap_btn = 1'b0;
    collide  = 1'b1;
    @(negedge clk);
    collide = 1'b0;
    @(negedge clk);
    wait_update("collide");
    flap_btn = 1'b1;
    @(negedge clk);
    flap_btn = 1'b0;
    check_all("collide", 190, 0, 1'b0, 1'b1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_all("restart2", 200, 0, 1'b0, 1'b0);

    // 5: flap on every tick (rise on the update cycle) up to the ceiling
    for (int i = 1; i <= 33; i++) begin
      wait_update("climb");
      flap_btn = 1'b1;
      @(negedge clk);
      flap_btn = 1'b0;
      check_all("climb", 200 - 6 * i, -96, 1'b1, 1'b0);
    end
    wait_update("ceil");
    flap_btn = 1'b1;
    @(negedge clk);
    flap_btn = 1'b0;
`ifdef BIRD_CEIL_CLAMP_EN
    check_all("ceil", 0, 0, 1'b1, 1'b0);
    wait_update("ceil_next");
    @(negedge clk);
    check_all("ceil_next", 2, 32, 1'b1, 1'b0);
`else
    check_all("ceil", 0, 0, 1'b0, 1'b1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_all("restart3", 200, 0, 1'b0, 1'b0);
    flap_btn = 1'b1;
    wait_update("rerun");
    @(negedge clk);
    flap_btn = 1'b0;
    check_all("rerun", 194, -96, 1'b1, 1'b0);
`endif

    // asynchronous reset in the middle of a game
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 200, 0, 1'b0, 1'b0);
    check("async_rst_tick", tick_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_tick1", tick_o, 0);
    @(negedge clk);
    check("post_rst_tick2", tick_o, 0);
    @(negedge clk);
    check("post_rst_tick3", tick_o, 1);
    check_all("post_rst", 200, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
